des_key_scheduler: RTL and testbench
====================================

Name: des_key_scheduler

Overview:
- Sequences the DES key schedule: accepts a 64-bit key, applies PC-1 once, then steps the 28-bit C/D halves through the 16-round rotation schedule.
- Emits one 48-bit PC-2 subkey per accepted handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits between the key-load interface and the round datapath, and is the only block that drives the round-key input of that datapath.
- Reuses the existing PC2 permutation module; PC-1 is instantiated as a sibling combinational permutation.

Parameters:
- None. Widths and the shift schedule are fixed by DES.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  key presented
- key_ready  out  1  scheduler idle and able to accept a key
- key  in  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,..,64 ignored
- decrypt  in  1  sampled with key: 0 = K1 first, 1 = K16 first
- abort  in  1  synchronous cancel of the current schedule
- subkey_valid  out  1  subkey and key_index valid
- subkey_ready  in  1  downstream consumes the subkey
- subkey  out  [1:48]  PC2(C,D) of the current state
- key_index  out  4  DES subkey number minus 1 (0 = K1, 15 = K16)
- last  out  1  high with subkey_valid on the 16th subkey
- done  out  1  one-cycle pulse after the 16th handshake

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, key_ready=1, subkey_valid=0, last=0, done=0, key_index=0.
  - C/D registers = 0, so subkey = PC2(0) = 0.
- FSM has two states, IDLE and RUN.
- IDLE:
  - key_ready=1.
  - On key_valid at a clock edge: latch decrypt into dir_r, set rnd=0, go to RUN.
  - Load C/D:
    - dir_r=0: C,D = rotl1(PC1(key)) halves, i.e. C1/D1.
    - dir_r=1: C,D = PC1(key) halves unrotated, i.e. C0/D0 = C16/D16.
- RUN:
  - key_ready=0; key_valid is ignored.
  - subkey_valid=1 from the first cycle after acceptance. Key-accept to first subkey latency is 1 cycle.
  - subkey is combinational PC2 of the C/D registers and holds stable while subkey_valid && !subkey_ready.
  - key_index = rnd when dir_r=0, 15-rnd when dir_r=1.
  - last = (rnd==15).
- Shift table, indexed by key_index j (0..15): S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- On a handshake (subkey_valid && subkey_ready) with rnd<15:
  - rnd increments.
  - dir_r=0: C,D rotate left by S[j+1].
  - dir_r=1: C,D rotate right by S[j].
  - Each half rotates independently, 28 bits with wrap.
  - The next subkey is valid the following cycle, so the maximum rate is 1 subkey/cycle with subkey_ready held high.
- On a handshake with rnd==15:
  - Go to IDLE and pulse done=1 for 1 cycle.
  - subkey_valid=0 and key_ready=1 in that same next cycle.
  - C/D are retained (not cleared).
- Full-rate pass: 16 subkeys in 16 cycles; a new key can be accepted in the cycle done is high.
- abort:
  - abort=1 at an edge in RUN: go to IDLE, subkey_valid=0, done stays 0, rnd=0. abort takes priority over a simultaneous handshake.
  - abort in IDLE has no effect. abort and key_valid together in IDLE: the key is accepted.
- Async reset mid-RUN: immediately returns to the reset values; a partially consumed schedule is discarded.
- decrypt and key changes during RUN have no effect.

Test Plan:
- Reset, then encrypt key 0x133457799BBCDFF1 with subkey_ready=1 -> subkey_valid 1 cycle after accept. K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, K16=0xCB3D8B0E17F5 with last=1. done 1 cycle after K16. Exactly 16 valid cycles.
- Same key with decrypt=1 -> first subkey 0xCB3D8B0E17F5 (key_index=15). Sequence is the exact reverse of the encrypt run. Last subkey 0x1B02EFFC7072 with key_index=0.
- Encrypt with subkey_ready toggled randomly (including 5-cycle stalls) -> subkey and key_index hold stable during stalls; the same 16 values as the full-rate run.
- Key with all parity bits flipped (0x123456789ABCDEF0 vs 0x133457799BBCDFF1 parity variants) -> identical subkey sequence.
- abort asserted after K5 handshake -> next cycle subkey_valid=0, key_ready=1, done=0. New key accepted -> K1 restarts correctly.
- rst_n pulsed low mid-cycle at K9 -> outputs go to reset values without a clock edge. A subsequent key produces the full correct sequence.

Source files
------------

// File: rtl/des_key_scheduler.sv
// DES key schedule sequencer: PC-1 once at key load, then C/D rotations per
// handshake, emitting PC-2 subkeys K1..K16 (encrypt) or K16..K1 (decrypt).

module des_pc1 (
  input  logic [1:64] key,
  output logic [1:56] cd
);
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  for (genvar i = 0; i < 56; i++) begin : g_bit
    assign cd[i+1] = key[PC1[i]];
  end

  // parity bits never reach the schedule
  logic unused_parity;
  assign unused_parity = ^{key[8], key[16], key[24], key[32],
                           key[40], key[48], key[56], key[64]};
endmodule

module des_pc2 (
  input  logic [1:56] cd,
  output logic [1:48] subkey
);
  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign subkey[i+1] = cd[PC2[i]];
  end

  logic unused_cd;
  assign unused_cd = ^{cd[9], cd[18], cd[22], cd[25],
                       cd[35], cd[38], cd[43], cd[54]};
endmodule

module des_key_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [1:64] key,
  input  logic        decrypt,
  input  logic        abort,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [1:48] subkey,
  output logic [3:0]  key_index,
  output logic        last,
  output logic        done
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [1:28] c_q, d_q;
  logic [3:0]  rnd_q;
  logic        dir_q, done_q;
  logic [1:56] cd0;
  logic        hs;

  des_pc1 u_pc1 (.key(key), .cd(cd0));
  des_pc2 u_pc2 (.cd({c_q, d_q}), .subkey(subkey));

  // shift of 2 everywhere except subkeys 1, 2, 9, 16
  function automatic logic shift2(input logic [3:0] j);
    return !(j == 4'd0 || j == 4'd1 || j == 4'd8 || j == 4'd15);
  endfunction

  function automatic logic [1:28] rot(input logic [1:28] x, input logic left,
                                      input logic two);
    case ({left, two})
      2'b11:   return {x[3:28], x[1:2]};
      2'b10:   return {x[2:28], x[1]};
      2'b01:   return {x[27:28], x[1:26]};
      default: return {x[28], x[1:27]};
    endcase
  endfunction

  assign hs = subkey_valid && subkey_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    key_ready    = 1'b0;
    subkey_valid = 1'b0;
    last         = 1'b0;
    done         = done_q;
    key_index    = dir_q ? 4'd15 - rnd_q : rnd_q;
    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_d = RUN;
      end
      RUN: begin
        subkey_valid = 1'b1;
        last         = (rnd_q == 4'd15);
        if (abort || (hs && rnd_q == 4'd15)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= '0;
      d_q    <= '0;
      rnd_q  <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == RUN) && !abort && hs && (rnd_q == 4'd15);
      if (state_q == IDLE) begin
        if (key_valid) begin
          dir_q <= decrypt;
          rnd_q <= '0;
          // decrypt starts from C0/D0, which equals C16/D16
          c_q   <= decrypt ? cd0[1:28]  : rot(cd0[1:28], 1'b1, 1'b0);
          d_q   <= decrypt ? cd0[29:56] : rot(cd0[29:56], 1'b1, 1'b0);
        end
      end else if (abort) begin
        rnd_q <= '0;
      end else if (hs && rnd_q != 4'd15) begin
        rnd_q <= rnd_q + 4'd1;
        c_q   <= rot(c_q, !dir_q, dir_q ? shift2(key_index) : shift2(key_index + 4'd1));
        d_q   <= rot(d_q, !dir_q, dir_q ? shift2(key_index) : shift2(key_index + 4'd1));
      end
    end
  end
endmodule

// File: tb/tb_des_key_scheduler.sv
// Directed bench for des_key_scheduler with an expected-subkey scoreboard.

module tb_des_key_scheduler;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        key_valid = 1'b0, decrypt = 1'b0, abort = 1'b0, subkey_ready = 1'b0;
  logic [1:64] key = '0;
  logic        key_ready, subkey_valid, last, done;
  logic [1:48] subkey;
  logic [3:0]  key_index;

  always #5 clk = ~clk;

  des_key_scheduler dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key(key), .decrypt(decrypt), .abort(abort), .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready), .subkey(subkey), .key_index(key_index),
    .last(last), .done(done));

  typedef struct packed {
    logic [3:0]  idx;
    logic [47:0] sk;
    logic        lst;
  } exp_t;

  // published subkeys K1..K16 for key 133457799BBCDFF1
  localparam logic [47:0] KE [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_key_ready"}, key_ready, 1);
    chk({tag, "_subkey_valid"}, subkey_valid, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_key_index"}, key_index, 0);
    chk({tag, "_subkey"}, subkey, 0);
  endtask

  // One schedule: accept k, consume subkeys, optionally abort or reset mid-run.
  task automatic run(input logic [63:0] k, input logic dec, input bit rnd_stall,
                     input int abort_at, input int rst_at, input bit abort_acc);
    int hs, vcyc, stall;
    bit did5;
    exp_t e;
    hs = 0; vcyc = 0; stall = 0; did5 = 0;
    @(negedge clk);
    chk("accept_ready", key_ready, 1);
    key = k; decrypt = dec; key_valid = 1'b1; abort = abort_acc;
    sb.delete();
    for (int j = 0; j < 16; j++) begin
      int x;
      x = dec ? 15 - j : j;
      e.idx = 4'(x); e.sk = KE[x]; e.lst = (j == 15);
      sb.push_back(e);
    end
    @(negedge clk);
    key_valid = 1'b0; abort = 1'b0; key = ~k; decrypt = ~dec;
    chk("first_latency", subkey_valid, 1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!subkey_valid) begin
        chk("valid_drop", subkey_valid, 1);
        return;
      end
      vcyc++;
      if (sb.size() == 0) begin
        chk("extra_valid", subkey_valid, 0);
        return;
      end
      chk("subkey", subkey, sb[0].sk);
      chk("key_index", key_index, sb[0].idx);
      chk("last", last, sb[0].lst);
      if (stall > 0) begin
        subkey_ready = 1'b0; stall--;
      end else if (rnd_stall && hs == 3 && !did5) begin
        subkey_ready = 1'b0; stall = 4; did5 = 1;
      end else if (rnd_stall) begin
        subkey_ready = 1'($urandom_range(0, 1));
      end else begin
        subkey_ready = 1'b1;
      end
      if (rst_at != 0 && hs == rst_at) begin
        subkey_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        return;
      end
      if (abort_at != 0 && hs == abort_at) begin
        subkey_ready = 1'b1;  // abort must win over this handshake
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; subkey_ready = 1'b0;
        chk("abort_valid", subkey_valid, 0);
        chk("abort_ready", key_ready, 1);
        chk("abort_done", done, 0);
        sb.delete();
        return;
      end
      if (subkey_ready) begin
        void'(sb.pop_front());
        hs++;
      end
      if (hs == 16) break;
      @(negedge clk);
    end
    if (hs != 16) begin
      chk("timeout_handshakes", hs, 16);
      return;
    end
    @(negedge clk);
    subkey_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_valid", subkey_valid, 0);
    chk("done_key_ready", key_ready, 1);
    if (!rnd_stall) chk("valid_cycles", vcyc, 16);
    @(negedge clk);
    chk("done_clear", done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    run(64'h133457799BBCDFF1, 1'b0, 1'b0, 0, 0, 1'b0);
    run(64'h133457799BBCDFF1, 1'b1, 1'b0, 0, 0, 1'b0);
    run(64'h133457799BBCDFF1, 1'b0, 1'b1, 0, 0, 1'b0);
    run(64'h123556789ABDDEF0, 1'b0, 1'b0, 0, 0, 1'b0);
    run(64'h123456789ABCDEF0, 1'b1, 1'b1, 0, 0, 1'b0);
    run(64'h133457799BBCDFF1, 1'b0, 1'b0, 5, 0, 1'b0);
    run(64'h133457799BBCDFF1, 1'b0, 1'b0, 0, 0, 1'b0);
    run(64'h133457799BBCDFF1, 1'b0, 1'b0, 0, 8, 1'b0);
    run(64'h133457799BBCDFF1, 1'b0, 1'b0, 0, 0, 1'b1);
    run(64'h133457799BBCDFF1, 1'b1, 1'b1, 0, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
